// File: rtl/alu8_exec_stage.sv
// Registered execute stage of the Simple ALU.
// Logic and pass ops finish at the accept edge. ADD/SUB run bit-serially, LSB first,
// one bit per clock. The result and flags are held under a valid/ready handshake.
module alu8_exec_stage #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             flag_z,
   output logic             flag_c,
   output logic             flag_n,
   output logic             busy
);

   localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   localparam logic [2:0] OP_AND    = 3'b000;
   localparam logic [2:0] OP_OR     = 3'b001;
   localparam logic [2:0] OP_XOR    = 3'b010;
   localparam logic [2:0] OP_NOT    = 3'b011;
   localparam logic [2:0] OP_ADD    = 3'b100;
   localparam logic [2:0] OP_SUB    = 3'b101;
   localparam logic [2:0] OP_PASS_A = 3'b110;
   localparam logic [2:0] OP_PASS_B = 3'b111;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SERIAL = 2'd1,
      DONE   = 2'd2
   } state_t;

   // Single-cycle result for every op that is not ADD/SUB.
   function automatic logic [WIDTH-1:0] logic_eval(input logic [2:0]       f_op,
                                                   input logic [WIDTH-1:0] x,
                                                   input logic [WIDTH-1:0] y);
      logic [WIDTH-1:0] r;
      r = '0;
      case (f_op)
         OP_AND:    r = x & y;
         OP_OR:     r = x | y;
         OP_XOR:    r = x ^ y;
         OP_NOT:    r = ~x;
         OP_PASS_A: r = x;
         OP_PASS_B: r = y;
         default:   r = '0;
      endcase
      return r;
   endfunction

   // Full-adder sum bit.
   function automatic logic fa_sum(input logic x, input logic y, input logic ci);
      return x ^ y ^ ci;
   endfunction

   // Full-adder carry: majority of the three inputs.
   function automatic logic fa_carry(input logic x, input logic y, input logic ci);
      return (x & y) | (x & ci) | (y & ci);
   endfunction

   state_t           state_q;
   state_t           state_d;

   logic             accept;
   logic             is_serial_op;
   logic             last_step;
   logic [WIDTH-1:0] logic_res;

   // Serial datapath registers. a_p0/b_p0 shift right so bit 0 is always the
   // current bit. acc_p0 collects sum bits from the top down.
   logic [WIDTH-1:0] a_p0;
   logic [WIDTH-1:0] b_p0;
   logic [WIDTH-2:0] acc_p0;
   logic             carry_p0;
   logic [CNT_W-1:0] cnt_p0;

   logic             bit_sum;
   logic             bit_carry;
   logic [WIDTH-1:0] acc_shift;

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q == SERIAL);

   assign accept       = in_valid && (state_q == IDLE);
   assign is_serial_op = (op == OP_ADD) || (op == OP_SUB);
   assign logic_res    = logic_eval(op, a, b);

   assign bit_sum   = fa_sum(a_p0[0], b_p0[0], carry_p0);
   assign bit_carry = fa_carry(a_p0[0], b_p0[0], carry_p0);
   assign acc_shift = {bit_sum, acc_p0};
   assign last_step = (state_q == SERIAL) && (cnt_p0 == CNT_LAST);

   // State register. Reset aborts any serial op in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. A release from DONE always passes through IDLE, so a
   // release and a new accept never happen at the same edge.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d = is_serial_op ? SERIAL : DONE;
            end
         end
         SERIAL: begin
            if (cnt_p0 == CNT_LAST) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // ---- stage p0: operand capture and one bit-step per clock ----
   // Load operands at accept. For SUB, b is stored inverted and carry starts at 1,
   // which gives two's-complement subtraction.
   always_ff @(posedge clk) begin
      if (accept) begin
         a_p0     <= a;
         b_p0     <= (op == OP_SUB) ? ~b : b;
         carry_p0 <= (op == OP_SUB);
         cnt_p0   <= '0;
         acc_p0   <= '0;
      end else if (state_q == SERIAL) begin
         a_p0     <= a_p0 >> 1;
         b_p0     <= b_p0 >> 1;
         carry_p0 <= bit_carry;
         cnt_p0   <= cnt_p0 + 1'b1;
         acc_p0   <= acc_shift[WIDTH-1:1];
      end
   end

   // ---- stage p1: architectural result and flags ----
   // These registers change only on the transition into DONE. A serial
   // computation in progress never shows up on result.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         result <= '0;
         flag_z <= 1'b0;
         flag_c <= 1'b0;
         flag_n <= 1'b0;
      end else if (accept && !is_serial_op) begin
         result <= logic_res;
         flag_z <= (logic_res == '0);
         flag_c <= 1'b0;
         flag_n <= logic_res[WIDTH-1];
      end else if (last_step) begin
         result <= acc_shift;
         flag_z <= (acc_shift == '0);
         flag_c <= bit_carry;
         flag_n <= acc_shift[WIDTH-1];
      end
   end

   // Result must stay stable while the consumer back-pressures.
   a_hold_stable : assert property (@(posedge clk) disable iff (!rst_n)
      (out_valid && !out_ready) |=> ($stable(result) && $stable(flag_z) &&
                                     $stable(flag_c) && $stable(flag_n)));

   // Only the three encoded states are ever reachable.
   a_state_legal : assert property (@(posedge clk) disable iff (!rst_n)
      (state_q != 2'd3));

endmodule

// File: tb/tb_alu8_exec_stage.sv
// Directed bench for alu8_exec_stage (WIDTH=8). A vector table covers every opcode.
// Hand-written sequences cover back-pressure, mid-op reset and back-to-back issue.
module tb_alu8_exec_stage;

   localparam logic [2:0] OP_AND    = 3'b000;
   localparam logic [2:0] OP_OR     = 3'b001;
   localparam logic [2:0] OP_XOR    = 3'b010;
   localparam logic [2:0] OP_NOT    = 3'b011;
   localparam logic [2:0] OP_ADD    = 3'b100;
   localparam logic [2:0] OP_SUB    = 3'b101;
   localparam logic [2:0] OP_PASS_A = 3'b110;
   localparam logic [2:0] OP_PASS_B = 3'b111;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a;
   logic [7:0] b;
   logic [2:0] op;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] result;
   logic       flag_z;
   logic       flag_c;
   logic       flag_n;
   logic       busy;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   alu8_exec_stage #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flag_z    (flag_z),
      .flag_c    (flag_c),
      .flag_n    (flag_n),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      logic [2:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] res;
      logic       z;
      logic       c;
      logic       n;
      int         lat;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait for in_ready, present one op for one accept edge, then count the edges
   // after the accept edge until out_valid. Busy cycles are counted along the way.
   task automatic issue(input logic [2:0] f_op, input logic [7:0] fa, input logic [7:0] fb,
                        output int lat, output int busy_cnt, output bit ok);
      int n;
      n = 0;
      lat = 0;
      busy_cnt = 0;
      ok = 1'b0;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      if (!in_ready) begin
         check("in_ready_timeout", 32'(in_ready), 32'd1);
         return;
      end
      in_valid = 1'b1;
      op = f_op;
      a = fa;
      b = fb;
      tick();
      in_valid = 1'b0;
      while (!out_valid && lat < 50) begin
         if (busy) busy_cnt++;
         tick();
         lat++;
      end
      ok = out_valid;
      if (!ok) check("out_valid_timeout", 32'(out_valid), 32'd1);
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   vec_t vecs[13];
   int   lat;
   int   bcnt;
   bit   ok;
   int   acc1;
   int   acc2;
   logic [7:0] held;

   initial begin
      vecs[0]  = '{OP_AND,    8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 0};
      vecs[1]  = '{OP_OR,     8'h55, 8'hAA, 8'hFF, 1'b0, 1'b0, 1'b1, 0};
      vecs[2]  = '{OP_XOR,    8'hA5, 8'hA5, 8'h00, 1'b1, 1'b0, 1'b0, 0};
      vecs[3]  = '{OP_NOT,    8'h00, 8'h12, 8'hFF, 1'b0, 1'b0, 1'b1, 0};
      vecs[4]  = '{OP_ADD,    8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 8};
      vecs[5]  = '{OP_SUB,    8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 1'b1, 8};
      vecs[6]  = '{OP_SUB,    8'h07, 8'h05, 8'h02, 1'b0, 1'b1, 1'b0, 8};
      vecs[7]  = '{OP_PASS_A, 8'h80, 8'h11, 8'h80, 1'b0, 1'b0, 1'b1, 0};
      vecs[8]  = '{OP_PASS_B, 8'h3C, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 0};
      vecs[9]  = '{OP_ADD,    8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 8};
      vecs[10] = '{OP_SUB,    8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 8};
      vecs[11] = '{OP_ADD,    8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b0, 8};
      vecs[12] = '{OP_AND,    8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1, 0};

      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      a = 8'h00;
      b = 8'h00;
      op = OP_AND;
      tick();
      tick();
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_result", 32'(result), 32'h00);
      check("rst_flags", 32'({flag_z, flag_c, flag_n}), 32'd0);
      rst_n = 1'b1;
      tick();

      // Table: every opcode, then handshake release
      for (int i = 0; i < 13; i++) begin
         issue(vecs[i].op, vecs[i].a, vecs[i].b, lat, bcnt, ok);
         if (ok) begin
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("v%0d_busy_cycles", i), 32'(bcnt), 32'(vecs[i].lat));
            check($sformatf("v%0d_result", i), 32'(result), 32'(vecs[i].res));
            check($sformatf("v%0d_zcn", i), 32'({flag_z, flag_c, flag_n}),
                  32'({vecs[i].z, vecs[i].c, vecs[i].n}));
            check($sformatf("v%0d_in_ready_done", i), 32'(in_ready), 32'd0);
            release_result();
            check($sformatf("v%0d_released", i), 32'(out_valid), 32'd0);
            check($sformatf("v%0d_result_kept", i), 32'(result), 32'(vecs[i].res));
         end
      end

      // Back-pressure: NOT 00 held 5 cycles while a competing op is offered
      issue(OP_NOT, 8'h00, 8'h00, lat, bcnt, ok);
      in_valid = 1'b1;
      op = OP_AND;
      a = 8'h00;
      b = 8'h00;
      for (int k = 0; k < 5; k++) begin
         tick();
         check($sformatf("bp%0d_out_valid", k), 32'(out_valid), 32'd1);
         check($sformatf("bp%0d_result", k), 32'(result), 32'hFF);
         check($sformatf("bp%0d_flag_n", k), 32'(flag_n), 32'd1);
         check($sformatf("bp%0d_in_ready", k), 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      release_result();
      check("bp_rel_in_ready", 32'(in_ready), 32'd1);
      check("bp_rel_out_valid", 32'(out_valid), 32'd0);
      check("bp_rel_result", 32'(result), 32'hFF);
      issue(OP_AND, 8'h0F, 8'h3C, lat, bcnt, ok);
      check("bp_next_result", 32'(result), 32'h0C);
      check("bp_next_latency", 32'(lat), 32'd0);
      release_result();

      // Reset asserted during the third serial cycle of ADD 0F+01
      in_valid = 1'b1;
      op = OP_ADD;
      a = 8'h0F;
      b = 8'h01;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      check("mid_busy_before_rst", 32'(busy), 32'd1);
      rst_n = 1'b0;
      tick();
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_result", 32'(result), 32'h00);
      check("mid_rst_in_ready", 32'(in_ready), 32'd1);
      rst_n = 1'b1;
      tick();
      issue(OP_ADD, 8'h0F, 8'h01, lat, bcnt, ok);
      check("post_rst_result", 32'(result), 32'h10);
      check("post_rst_latency", 32'(lat), 32'd8);
      check("post_rst_zcn", 32'({flag_z, flag_c, flag_n}), 32'd0);
      release_result();

      // Back-to-back OR then PASS b, with out_ready held high
      out_ready = 1'b1;
      in_valid = 1'b1;
      op = OP_OR;
      a = 8'h55;
      b = 8'hAA;
      acc1 = cyc;
      tick();
      check("b2b_first_valid", 32'(out_valid), 32'd1);
      check("b2b_first_result", 32'(result), 32'hFF);
      check("b2b_first_n", 32'(flag_n), 32'd1);
      op = OP_PASS_B;
      a = 8'h00;
      b = 8'h80;
      tick();
      check("b2b_gap_in_ready", 32'(in_ready), 32'd1);
      acc2 = cyc;
      check("b2b_accept_spacing", 32'(acc2 - acc1), 32'd2);
      tick();
      in_valid = 1'b0;
      check("b2b_second_valid", 32'(out_valid), 32'd1);
      check("b2b_second_result", 32'(result), 32'h80);
      check("b2b_second_n", 32'(flag_n), 32'd1);
      held = result;
      tick();
      out_ready = 1'b0;
      check("b2b_end_out_valid", 32'(out_valid), 32'd0);
      check("b2b_end_result", 32'(result), 32'(held));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
